// File: rtl/rf_arb_pkg.sv
// Shared types for the register-file access arbiter.
package rf_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } arb_state_e;

   typedef enum logic [1:0] {
      RESP_OK  = 2'd0,
      RESP_INV = 2'd1,
      RESP_TMO = 2'd2
   } arb_resp_e;

endpackage

// File: rtl/rf_rr_pick2.sv
// Two-way round-robin picker: a lone request always wins, the pointer only
// breaks ties (ptr_i = 0 favours requester 0).
module rf_rr_pick2 (
   input  logic [1:0] req_i,
   input  logic       ptr_i,
   output logic [1:0] gnt_o
);

   // one-hot grant from the request pair and the tie-break pointer
   always_comb begin
      gnt_o = 2'b00;
      case (req_i)
         2'b01:   gnt_o = 2'b01;
         2'b10:   gnt_o = 2'b10;
         2'b11:   gnt_o = ptr_i ? 2'b10 : 2'b01;
         default: gnt_o = 2'b00;
      endcase
   end

endmodule

// File: rtl/rf_access_arbiter.sv
// Shares the HMC register-file port between the link-init sequencer (0) and
// the host config bridge (1). One access in flight, per-access timeout.
//
//   state | meaning
//   IDLE  | waiting for a request; picks and latches the winner
//   ISSUE | one-cycle read/write strobe to the register file
//   WAIT  | counting cycles until access-complete or timeout
//   RESP  | one-cycle ack to the winner; pointer moves to the other side
module rf_access_arbiter
   import rf_arb_pkg::*;
#(
   parameter int HMC_RF_WWIDTH  = 64,
   parameter int HMC_RF_RWIDTH  = 64,
   parameter int HMC_RF_AWIDTH  = 4,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                     clk,
   input  logic                     res_n,
   input  logic                     req_0,
   input  logic                     we_0,
   input  logic [HMC_RF_AWIDTH-1:0] addr_0,
   input  logic [HMC_RF_WWIDTH-1:0] wdata_0,
   output logic                     ack_0,
   output logic [HMC_RF_RWIDTH-1:0] rdata_0,
   output logic                     err_inv_0,
   output logic                     err_tmo_0,
   input  logic                     req_1,
   input  logic                     we_1,
   input  logic [HMC_RF_AWIDTH-1:0] addr_1,
   input  logic [HMC_RF_WWIDTH-1:0] wdata_1,
   output logic                     ack_1,
   output logic [HMC_RF_RWIDTH-1:0] rdata_1,
   output logic                     err_inv_1,
   output logic                     err_tmo_1,
   output logic [HMC_RF_AWIDTH-1:0] rf_address,
   output logic [HMC_RF_WWIDTH-1:0] rf_write_data,
   output logic                     rf_read_enable,
   output logic                     rf_write_enable,
   input  logic [HMC_RF_RWIDTH-1:0] rf_read_data,
   input  logic                     rf_access_complete,
   input  logic                     rf_invalid_address
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

   arb_state_e               state_q, state_d;
   logic                     ptr_q, ptr_d;
   logic                     win_q, win_d;
   logic                     we_q, we_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic [HMC_RF_AWIDTH-1:0] addr_q, addr_d;
   logic [HMC_RF_WWIDTH-1:0] wdata_q, wdata_d;
   logic                     rd_en_q, rd_en_d;
   logic                     wr_en_q, wr_en_d;
   logic [1:0]               ack_q, ack_d;
   logic [1:0]               inv_q, inv_d;
   logic [1:0]               tmo_q, tmo_d;
   logic [HMC_RF_RWIDTH-1:0] rdata0_q, rdata0_d;
   logic [HMC_RF_RWIDTH-1:0] rdata1_q, rdata1_d;

   logic [1:0]               gnt;
   logic                     done;
   arb_resp_e                resp;
   logic [HMC_RF_RWIDTH-1:0] rsp_data;

   rf_rr_pick2 u_pick (
      .req_i ({req_1, req_0}),
      .ptr_i (ptr_q),
      .gnt_o (gnt)
   );

   // next-state, latch updates and registered-output next values
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      win_d   = win_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      cnt_d   = cnt_q;
      rd_en_d = 1'b0;
      wr_en_d = 1'b0;
      done    = 1'b0;
      resp    = RESP_OK;

      case (state_q)
         IDLE: begin
            if (gnt != 2'b00) begin
               win_d   = gnt[1];
               we_d    = gnt[1] ? we_1    : we_0;
               addr_d  = gnt[1] ? addr_1  : addr_0;
               wdata_d = gnt[1] ? wdata_1 : wdata_0;
               rd_en_d = ~we_d;
               wr_en_d = we_d;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            cnt_d = CNT_W'(1);
            if (rf_access_complete) begin
               done    = 1'b1;
               resp    = rf_invalid_address ? RESP_INV : RESP_OK;
               state_d = RESP;
            end else begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            // a completion in the terminal-count cycle still wins over timeout
            if (rf_access_complete) begin
               done    = 1'b1;
               resp    = rf_invalid_address ? RESP_INV : RESP_OK;
               state_d = RESP;
            end else if (cnt_q == CNT_MAX) begin
               done    = 1'b1;
               resp    = RESP_TMO;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RESP: begin
            ptr_d   = ~win_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      rsp_data = (resp == RESP_OK && !we_q) ? rf_read_data : '0;
      ack_d    = {done & win_q, done & ~win_q};
      inv_d    = (resp == RESP_INV) ? ack_d : 2'b00;
      tmo_d    = (resp == RESP_TMO) ? ack_d : 2'b00;
      rdata0_d = ack_d[0] ? rsp_data : '0;
      rdata1_d = ack_d[1] ? rsp_data : '0;
   end

   // state and all output registers; reset abandons any access in flight
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         state_q  <= IDLE;
         ptr_q    <= 1'b0;
         win_q    <= 1'b0;
         we_q     <= 1'b0;
         cnt_q    <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rd_en_q  <= 1'b0;
         wr_en_q  <= 1'b0;
         ack_q    <= 2'b00;
         inv_q    <= 2'b00;
         tmo_q    <= 2'b00;
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         win_q    <= win_d;
         we_q     <= we_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rd_en_q  <= rd_en_d;
         wr_en_q  <= wr_en_d;
         ack_q    <= ack_d;
         inv_q    <= inv_d;
         tmo_q    <= tmo_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
      end
   end

   assign rf_address      = addr_q;
   assign rf_write_data   = wdata_q;
   assign rf_read_enable  = rd_en_q;
   assign rf_write_enable = wr_en_q;
   assign ack_0           = ack_q[0];
   assign ack_1           = ack_q[1];
   assign err_inv_0       = inv_q[0];
   assign err_inv_1       = inv_q[1];
   assign err_tmo_0       = tmo_q[0];
   assign err_tmo_1       = tmo_q[1];
   assign rdata_0         = rdata0_q;
   assign rdata_1         = rdata1_q;

endmodule

// File: doc/rf_access_arbiter.md
# rf_access_arbiter

Shares the single HMC controller register-file port (address, write data, read/write enables, read data, access-complete, invalid-address) between two independent requesters: requester 0 (link init/training sequencer) and requester 1 (host configuration bus bridge). Round-robin arbitration, exactly one outstanding access, per-access timeout, registered error/response reporting back to the winning requester.

## Interface
Parameters:
- HMC_RF_WWIDTH, 64, register-file write data width
- HMC_RF_RWIDTH, 64, register-file read data width
- HMC_RF_AWIDTH, 4, register-file address width
- TIMEOUT_CYCLES, 255, max cycles from enable pulse to access-complete; must be ≥2

Ports (n = 0,1 for each requester group):
- clk  in  1  single clock; all logic on rising edge
- res_n  in  1  reset, asynchronous, active-low
- req_n  in  1  access request; held with cmd fields stable until ack_n
- we_n  in  1  1 = write, 0 = read
- addr_n  in  HMC_RF_AWIDTH  register address
- wdata_n  in  HMC_RF_WWIDTH  write data
- ack_n  out  1  one-cycle completion pulse
- rdata_n  out  HMC_RF_RWIDTH  read data, valid with ack_n (zero for writes/errors)
- err_inv_n  out  1  with ack_n: register file flagged invalid address
- err_tmo_n  out  1  with ack_n: access timed out
- rf_address  out  HMC_RF_AWIDTH  to register file
- rf_write_data  out  HMC_RF_WWIDTH  to register file
- rf_read_enable  out  1  one-cycle read strobe
- rf_write_enable  out  1  one-cycle write strobe
- rf_read_data  in  HMC_RF_RWIDTH  from register file, valid with rf_access_complete
- rf_access_complete  in  1  access done pulse
- rf_invalid_address  in  1  qualifies rf_access_complete

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req_n high, select winner (both high → requester named by priority pointer); latch we/addr/wdata and winner id; → ISSUE. No request → stay.
- ISSUE: exactly one of rf_read_enable/rf_write_enable high for this one cycle; rf_address/rf_write_data driven from latch (held through WAIT); timeout counter cleared to 1; → WAIT, or → RESP directly if rf_access_complete already high.
- WAIT: counter increments each cycle. rf_access_complete → capture rf_read_data (reads only) and rf_invalid_address; → RESP. Counter reaches TIMEOUT_CYCLES without complete → set timeout flag; → RESP.
- RESP: ack of winner high one cycle with rdata/err flags; priority pointer set to the other requester; → IDLE.
- Complete takes precedence over timeout in the same cycle.
- rf_access_complete outside ISSUE/WAIT (e.g. late after timeout) ignored, no state change.
- Requester dropping req before ack: access still completes, ack still pulses; requester ignores it.
- Requester keeping req high after ack: treated as a new request in following IDLE (subject to round-robin).
- Reset (any state, mid-access included): FSM → IDLE, all outputs 0, priority pointer → requester 0, latches cleared. Abandoned register-file access is not reported.

## Timing
- All outputs registered; reset value 0 for every output.
- Req sampled high in IDLE at cycle T → enable strobe at T+1 → earliest ack at T+2 (complete in ISSUE) ; general: complete at cycle C → ack at C+1.
- Timeout: enable at T+1, no complete → ack with err_tmo at T+1+TIMEOUT_CYCLES+1.
- Back-to-back: minimum 4 cycles per access (IDLE, ISSUE, WAIT, RESP) when complete arrives in WAIT's first cycle.
- Timeout counter width: $clog2(TIMEOUT_CYCLES+1); no wrap, saturates by leaving WAIT.

## Structure
- Package rf_arb_pkg: state enum (IDLE, ISSUE, WAIT, RESP), response enum (RESP_OK, RESP_INV, RESP_TMO).
- One sub-module: rf_rr_pick2 (2-way round-robin picker: req[1:0], pointer → one-hot grant), combinational.
- Everything else in rf_access_arbiter.

## Test plan
- Single read, req_0 addr=4'h3, complete 2 cycles after enable with rdata=64'hDEAD_BEEF_0000_0001 → one rf_read_enable pulse, rf_address=3, ack_0 with that rdata, errs 0.
- Simultaneous req_0 write addr 1, req_1 read addr 2, held across completions → order grants 0,1,0,1; never two enables in one cycle.
- Write to addr 4'hF, complete with rf_invalid_address=1 → ack_1 with err_inv_1=1, rdata_1=0.
- TIMEOUT_CYCLES=8, no complete → ack after exactly 9 cycles from enable with err_tmo=1; late complete 3 cycles later ignored, FSM stays IDLE.
- res_n low during WAIT → all outputs 0 immediately; after release, pending req_1 (pointer favoring 0 but req_0 low) granted normally.
- Complete coincident with timeout-count cycle → ack with err_tmo=0 and captured data.
